prog_rom: RTL
=============

# prog_rom

Programmable instruction ROM with parametrised width and depth. Firmware is loaded through a sequential load port, not preloaded. Reads use a registered valid/ready request/response handshake, with per-access error flagging for unprogrammed locations. It sits between the fetch stage and the boot/programming path, and gives firmware loading a real handshake into the storage array.

## Interface
Parameters:
- N, 64, depth in words
- DATA_W, 32, word width
- ADDR_W, $clog2(N), address width
- FILL_WORD, 32'h0000_0013, data returned for unprogrammed locations (sized to DATA_W)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  programming-mode request; high = load, low = run
- load_valid  in  1  load word present
- load_data  in  DATA_W  word written at the load pointer
- load_ready  out  1  load word accepted this cycle when high with load_valid
- load_count  out  $clog2(N+1)  number of programmed words (0..N)
- req_valid  in  1  read request present
- req_addr  in  ADDR_W  read address
- req_ready  out  1  request accepted when high with req_valid
- rsp_valid  out  1  response held
- rsp_data  out  DATA_W  read data
- rsp_err  out  1  addressed location ≥ load_count (unprogrammed)
- rsp_ready  in  1  consumer accepts response

## Operation
FSM states:
- RUN: reads enabled.
- DRAIN: waiting for an outstanding response to be accepted before programming.
- LOAD: programming in progress.

Transitions:
- RUN → LOAD: enable=1 and no response pending (rsp_valid=0, or rsp_valid&&rsp_ready this cycle). On entry, load_count clears to 0.
- RUN → DRAIN: enable=1 while a response is pending and not accepted this cycle.
- DRAIN → LOAD: on the cycle the response is accepted. load_count clears to 0.
- LOAD → RUN: enable=0. load_count is frozen.
- DRAIN with enable dropped: return to RUN, and load_count is preserved.

Load rules:
- load_ready = (state==LOAD) && (load_count<N).
- On an accepted load, store load_data at mem[load_count] and increment load_count.
- When load_count==N, further load_valid is ignored and there is no wrap.

Read rules:
- req_ready = (state==RUN) && (!rsp_valid || rsp_ready).
- On an accepted request, the response register captures:
  - rsp_data = mem[req_addr] if req_addr < load_count, else FILL_WORD.
  - rsp_err = (req_addr ≥ load_count).
- A response is held stable, with rsp_data and rsp_err unchanged, until rsp_valid&&rsp_ready.
- If req_addr ≥ N (non-power-of-two N), rsp_err=1 and rsp_data=FILL_WORD.

Reset:
- Async rst forces: state=RUN, load_count=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- Storage array is not reset. Reads after reset return FILL_WORD with err=1 because load_count is 0.
- Reset during LOAD discards programming progress.

## Timing
- Read latency is 1 cycle. A request accepted at edge k gives rsp_valid=1 after edge k.
- Throughput is one read per cycle while rsp_ready=1. There are no bubbles with back-to-back requests.
- Load throughput is one word per cycle.
- A word written at edge k is readable by any request accepted at or after edge k+1 once back in RUN.
- enable is sampled every cycle. There is a 1-cycle latency from enable rising to load_ready rising (no pending response).
- Reset outputs, asynchronously on rst assertion: load_ready=0, req_ready=0 until rst deasserts, then req_ready=1 next cycle.

## Structure
- prog_rom_pkg holds:
  - state_t enum {RUN, DRAIN, LOAD}
  - default FILL_WORD constant
- Sub-module prog_rom_mem: a single-write, single-read storage array with no reset, parametrised by N and DATA_W.
- The FSM, load pointer and response register live in prog_rom.

## Test plan
- Reset then read addr 0: rsp_valid after 1 cycle, rsp_data=32'h0000_0013, rsp_err=1.
- Program 4 words with enable=1: DEADBABE, DEAD0101, DEAD1234, DEAD8888.
  - Drop enable and read addrs 0–3 back-to-back with rsp_ready=1.
  - Expect those four words on consecutive cycles, err=0, load_count=4.
  - Then read addr 5: FILL_WORD, err=1.
- Backpressure: hold rsp_ready=0 with a response DEAD0101 pending.
  - Expect req_ready=0 and rsp_data stable for 5 cycles.
  - Release rsp_ready: the next request is accepted the same cycle.
- Raise enable with a response pending and rsp_ready=0.
  - Expect state DRAIN and load_ready=0.
  - Accept the response: next cycle load_ready=1 and load_count=0.
- Fill all N=64 words.
  - load_count=64 and load_ready=0. A 65th load_valid has no effect.
  - Read addr 63 returns the last word.
- Assert rst mid-load after 2 words.
  - Outputs go to reset values immediately.
  - Read addr 0 afterwards returns FILL_WORD with err=1.

Source files
------------

// File: rtl/prog_rom_pkg.sv
// prog_rom_pkg: shared state encoding and default fill word for the program ROM
package prog_rom_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
  localparam logic [31:0] FILL_WORD_DEF = 32'h0000_0013;
endpackage

// File: rtl/prog_rom_if.sv
// prog_rom_if: load port and read request/response bus of the program ROM
interface prog_rom_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 7
) ();
  logic              enable;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic [CNT_W-1:0]  load_count;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_ready;
  modport master (
    output enable, load_valid, load_data, req_valid, req_addr, rsp_ready,
    input  load_ready, load_count, req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  enable, load_valid, load_data, req_valid, req_addr, rsp_ready,
    output load_ready, load_count, req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/prog_rom_mem.sv
// prog_rom_mem: single-write, single-read storage array without reset
module prog_rom_mem #(
  parameter int N      = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [N];
  // write port; contents are only meaningful below the load pointer
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/prog_rom.sv
// prog_rom: loadable instruction ROM with registered read response and unprogrammed-word flagging
module prog_rom
  import prog_rom_pkg::*;
#(
  parameter int              N         = 64,
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = $clog2(N),
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF)
) (
  input logic       clk,
  input logic       rst,
  prog_rom_if.slave bus
);
  localparam int CNT_W = $clog2(N + 1);
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_count;
  logic              r_up, r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0] r_rsp_data, w_rdata;
  logic              w_rsp_take, w_req_take, w_load_take, w_clr, w_hit;

  assign w_rsp_take     = r_rsp_valid && bus.rsp_ready;
  assign bus.req_ready  = r_up && r_state == RUN && (!r_rsp_valid || bus.rsp_ready);
  assign w_req_take     = bus.req_valid && bus.req_ready;
  assign bus.load_ready = r_state == LOAD && r_count < CNT_W'(N);
  assign w_load_take    = bus.load_valid && bus.load_ready;
  // covers req_addr >= N too, since load_count never exceeds N
  assign w_hit          = CNT_W'(bus.req_addr) < r_count;
  assign w_clr          = w_next == LOAD && r_state != LOAD;
  assign bus.load_count = r_count;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;

  prog_rom_mem #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .i_we   (w_load_take),
    .i_waddr(ADDR_W'(r_count)),
    .i_wdata(bus.load_data),
    .i_raddr(bus.req_addr),
    .o_rdata(w_rdata)
  );

  // mode sequencing: a pending response must drain before programming starts
  always_comb begin
    w_next = r_state;
    if (r_state == RUN && bus.enable) w_next = (r_rsp_valid && !bus.rsp_ready) ? DRAIN : LOAD;
    else if (r_state == DRAIN) w_next = !bus.enable ? RUN : w_rsp_take ? LOAD : DRAIN;
    else if (r_state == LOAD && !bus.enable) w_next = RUN;
  end

  // state register; r_up holds req_ready low until the first edge after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= RUN;
      r_up    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_up    <= 1'b1;
    end

  // load pointer: restarts on entry to LOAD, saturates at N
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (w_clr) r_count <= '0;
    else if (w_load_take) r_count <= r_count + CNT_W'(1);

  // response register held until the consumer accepts it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_req_take) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_hit ? w_rdata : FILL_WORD;
      r_rsp_err   <= !w_hit;
    end else if (w_rsp_take) r_rsp_valid <= 1'b0;
endmodule
